// File: rtl/mlc_pkg.sv
// Shared types and sizing helpers for the multi-lane hash/target comparator.
package mlc_pkg;

  typedef enum logic [2:0] {
    DRAIN,
    LOAD,
    ARB,
    COMPARE,
    REPORT
  } state_e;

  // Number of CHUNK_W-bit slices walked per comparison.
  function automatic int nchunk(input int hash_w, input int chunk_w);
    return hash_w / chunk_w;
  endfunction

  // Number of 32-bit target words needed to fill the target register.
  function automatic int nwords(input int hash_w);
    return hash_w / 32;
  endfunction

endpackage

// File: rtl/mlc_rr_arbiter.sv
// Round-robin lane arbiter: one-hot grant searched from the lane after the
// last accepted grant; the pointer only moves on the advance strobe.
module mlc_rr_arbiter #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] req,
  input  logic             advance,
  output logic [LANES-1:0] grant
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic             found;
  int               idx;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < LANES; i++) begin
      idx = (int'(ptr_q) + i) % LANES;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (win == PTR_W'(LANES - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_lane_comparator.sv
// Arbitrates hash FIFO lanes and compares each hash chunk-wise against a target.
// Optional macro MLC_CONST_LATENCY_EN: every compare takes the full chunk count.
module multi_lane_comparator
  import mlc_pkg::*;
#(
  parameter int HASH_W  = 256,
  parameter int CHUNK_W = 64,
  parameter int LANES   = 4,
  parameter int NONCE_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  output logic                     stop_ack,
  input  logic [31:0]              target,
  input  logic                     target_valid,
  input  logic                     all_empty,
  input  logic [LANES*HASH_W-1:0]  hash_in,
  input  logic [LANES*NONCE_W-1:0] nonce_in,
  input  logic [LANES-1:0]         hash_empty,
  output logic [LANES-1:0]         hash_re,
  output logic                     golden_valid,
  input  logic                     golden_ready,
  output logic [NONCE_W-1:0]       golden_nonce,
  output logic [$clog2(LANES)-1:0] golden_lane,
  output logic [31:0]              hit_count
);

  localparam int NCHUNK = nchunk(HASH_W, CHUNK_W);
  localparam int NWORDS = nwords(HASH_W);
  localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int WD_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LANE_W = $clog2(LANES);

  state_e              state_q, state_d;
  logic [HASH_W-1:0]   tgt_q, tgt_d;
  logic [WD_W-1:0]     word_q, word_d;
  logic [CH_W-1:0]     chunk_q, chunk_d;
  logic [LANE_W-1:0]   lane_q, lane_d, gnt_idx;
  logic [LANE_W-1:0]   golden_lane_q, golden_lane_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic                golden_valid_q, golden_valid_d;
  logic [31:0]         hit_q, hit_d;
`ifdef MLC_CONST_LATENCY_EN
  logic                dec_q, dec_d, dhit_q, dhit_d;
`endif

  logic [LANES-1:0]    req, grant, hash_re_c;
  logic                advance, verdict, hit;
  logic [HASH_W-1:0]   hash_sel;
  logic [CHUNK_W-1:0]  h_chunk, t_chunk;

  assign req     = ~hash_empty;
  assign advance = (state_q == ARB) && (|req) && !stop;

  mlc_rr_arbiter #(.LANES(LANES)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(advance),
    .grant  (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) gnt_idx = LANE_W'(i);
    end
  end

  // Chunk 0 is the most significant slice of both hash and target.
  assign hash_sel = hash_in[int'(lane_q)*HASH_W +: HASH_W];
  assign h_chunk  = hash_sel[HASH_W-1-int'(chunk_q)*CHUNK_W -: CHUNK_W];
  assign t_chunk  = tgt_q[HASH_W-1-int'(chunk_q)*CHUNK_W -: CHUNK_W];

`ifdef MLC_CONST_LATENCY_EN
  assign verdict = (chunk_q == CH_W'(NCHUNK - 1));
  assign hit     = dec_q ? dhit_q : (h_chunk < t_chunk);
`else
  assign verdict = (h_chunk != t_chunk) || (chunk_q == CH_W'(NCHUNK - 1));
  assign hit     = (h_chunk < t_chunk);
`endif

  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    word_d         = word_q;
    chunk_d        = chunk_q;
    lane_d         = lane_q;
    golden_lane_d  = golden_lane_q;
    nonce_d        = nonce_q;
    golden_valid_d = golden_valid_q;
    hit_d          = hit_q;
    hash_re_c      = '0;
`ifdef MLC_CONST_LATENCY_EN
    dec_d          = dec_q;
    dhit_d         = dhit_q;
`endif
    if (stop && state_q != DRAIN) begin
      state_d        = DRAIN;
      golden_valid_d = 1'b0;
    end else begin
      case (state_q)
        DRAIN: begin
          if (!all_empty) begin
            hash_re_c = req;
          end else if (start) begin
            state_d = LOAD;
            word_d  = '0;
          end
        end
        LOAD: begin
          if (target_valid) begin
            tgt_d = {target, tgt_q[HASH_W-1:32]};
            if (word_q == WD_W'(NWORDS - 1)) begin
              word_d  = '0;
              state_d = ARB;
            end else begin
              word_d = word_q + WD_W'(1);
            end
          end
        end
        ARB: begin
          if (|req) begin
            lane_d  = gnt_idx;
            chunk_d = '0;
            state_d = COMPARE;
`ifdef MLC_CONST_LATENCY_EN
            dec_d   = 1'b0;
`endif
          end
        end
        COMPARE: begin
`ifdef MLC_CONST_LATENCY_EN
          if (!dec_q && h_chunk != t_chunk) begin
            dec_d  = 1'b1;
            dhit_d = (h_chunk < t_chunk);
          end
`endif
          if (verdict) begin
            hash_re_c[lane_q] = 1'b1;
            if (hit) begin
              nonce_d        = nonce_in[int'(lane_q)*NONCE_W +: NONCE_W];
              golden_lane_d  = lane_q;
              golden_valid_d = 1'b1;
              if (hit_q != '1) hit_d = hit_q + 32'd1;
              state_d        = REPORT;
            end else begin
              state_d = ARB;
            end
          end else begin
            chunk_d = chunk_q + CH_W'(1);
          end
        end
        REPORT: begin
          if (golden_ready) begin
            golden_valid_d = 1'b0;
            state_d        = ARB;
          end
        end
        default: state_d = DRAIN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= DRAIN;
      tgt_q          <= '0;
      word_q         <= '0;
      chunk_q        <= '0;
      lane_q         <= '0;
      golden_lane_q  <= '0;
      nonce_q        <= '0;
      golden_valid_q <= 1'b0;
      hit_q          <= '0;
`ifdef MLC_CONST_LATENCY_EN
      dec_q          <= 1'b0;
      dhit_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tgt_q          <= tgt_d;
      word_q         <= word_d;
      chunk_q        <= chunk_d;
      lane_q         <= lane_d;
      golden_lane_q  <= golden_lane_d;
      nonce_q        <= nonce_d;
      golden_valid_q <= golden_valid_d;
      hit_q          <= hit_d;
`ifdef MLC_CONST_LATENCY_EN
      dec_q          <= dec_d;
      dhit_q         <= dhit_d;
`endif
    end
  end

  // Pops follow the FIFO flags combinationally so a lane is never popped empty.
  assign hash_re      = rst ? '0 : hash_re_c;
  assign stop_ack     = rst || (state_q == DRAIN && all_empty);
  assign golden_valid = golden_valid_q;
  assign golden_nonce = nonce_q;
  assign golden_lane  = golden_lane_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_multi_lane_comparator.sv
// Directed bench for multi_lane_comparator with a FWFT FIFO model per lane.
module tb_multi_lane_comparator;

  localparam int HW = 256;
  localparam int NW = 64;
  localparam int L  = 4;
`ifdef MLC_CONST_LATENCY_EN
  localparam int LAT_FIRST = 4;
`else
  localparam int LAT_FIRST = 1;
`endif
  localparam int LAT_LAST = 4;

  localparam logic [HW-1:0] T_VAL  = {16'h0000, {240{1'b1}}};
  localparam logic [HW-1:0] ONES   = {HW{1'b1}};
  localparam logic [HW-1:0] HIT_H  = {32'h0000_0001, 224'h0};
  localparam logic [HW-1:0] LAST_H = {16'h0000, {239{1'b1}}, 1'b0};
  localparam logic [NW-1:0] NONCE_A = 64'hDEAD_BEEF_0123_4567;
  localparam logic [NW-1:0] NONCE_B = 64'h0BAD_F00D_CAFE_0042;

  typedef struct {
    int            lane;
    logic [HW-1:0] h;
    logic [NW-1:0] n;
  } push_t;

  logic            clk = 1'b0, rst = 1'b1;
  logic            start = 1'b0, stop = 1'b0, stop_ack;
  logic [31:0]     target = '0;
  logic            target_valid = 1'b0, all_empty;
  logic [L*HW-1:0] hash_in;
  logic [L*NW-1:0] nonce_in;
  logic [L-1:0]    hash_empty, hash_re;
  logic            golden_valid, golden_ready = 1'b0;
  logic [NW-1:0]   golden_nonce;
  logic [1:0]      golden_lane;
  logic [31:0]     hit_count;

  logic [HW-1:0]   mem_h [L][8];
  logic [NW-1:0]   mem_n [L][8];
  int              cnt [L];
  push_t           pq [$];
  int              pop_log [$];
  logic [L-1:0]    re_s;
  int              bad_pop = 0, multi = 0;
  bit              chk_single = 1'b0;
  int              n_chk = 0, n_fail = 0;

  multi_lane_comparator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .stop_ack    (stop_ack),
    .target      (target),
    .target_valid(target_valid),
    .all_empty   (all_empty),
    .hash_in     (hash_in),
    .nonce_in    (nonce_in),
    .hash_empty  (hash_empty),
    .hash_re     (hash_re),
    .golden_valid(golden_valid),
    .golden_ready(golden_ready),
    .golden_nonce(golden_nonce),
    .golden_lane (golden_lane),
    .hit_count   (hit_count)
  );

  always #5 clk = ~clk;

  function automatic void drive_fifos();
    all_empty = 1'b1;
    for (int l = 0; l < L; l++) begin
      hash_empty[l]         = (cnt[l] == 0);
      hash_in[l*HW +: HW]   = mem_h[l][0];
      nonce_in[l*NW +: NW]  = mem_n[l][0];
      if (cnt[l] != 0) all_empty = 1'b0;
    end
  endfunction

  // FIFO model: sample pops mid-cycle, apply them (then queued pushes) after the edge.
  always begin
    @(negedge clk);
    re_s = hash_re;
    for (int l = 0; l < L; l++) begin
      if (re_s[l]) begin
        if (cnt[l] == 0) bad_pop++;
        else             pop_log.push_back(l);
      end
    end
    if (chk_single && $countones(re_s) > 1) multi++;
    @(posedge clk);
    #1;
    for (int l = 0; l < L; l++) begin
      if (re_s[l] && cnt[l] > 0) begin
        for (int k = 0; k < 7; k++) begin
          mem_h[l][k] = mem_h[l][k+1];
          mem_n[l][k] = mem_n[l][k+1];
        end
        cnt[l]--;
      end
    end
    while (pq.size() > 0) begin
      push_t p;
      p = pq.pop_front();
      if (cnt[p.lane] < 8) begin
        mem_h[p.lane][cnt[p.lane]] = p.h;
        mem_n[p.lane][cnt[p.lane]] = p.n;
        cnt[p.lane]++;
      end
    end
    drive_fifos();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int lane, input logic [HW-1:0] h, input logic [NW-1:0] n);
    push_t p;
    p.lane = lane;
    p.h    = h;
    p.n    = n;
    pq.push_back(p);
  endtask

  // Latency = compare cycles from grant to the pop pulse (ARB cycle excluded).
  task automatic push_measure(input int lane, input logic [HW-1:0] h,
                              input logic [NW-1:0] n, output int lat);
    lat = -1;
    tick();
    push(lane, h, n);
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      @(negedge clk);
      if (hash_re != '0) lat = c - 2;
    end
  endtask

  task automatic wait_pops(input int k);
    for (int c = 0; c < 80 && pop_log.size() < k; c++) @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (golden_valid) ok = 1'b1;
    end
  endtask

  task automatic load_target(input logic [HW-1:0] t);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < HW / 32; i++) begin
      target       = t[i*32 +: 32];
      target_valid = 1'b1;
      tick();
    end
    target_valid = 1'b0;
  endtask

  task automatic test_reset();
    push(0, ONES, 64'h1);
    repeat (2) @(negedge clk);
    n_chk++; if (hash_re !== 4'b0000) begin n_fail++; $display("FAIL reset_hash_re: got %b want 0000", hash_re); end
    n_chk++; if (stop_ack !== 1'b1) begin n_fail++; $display("FAIL reset_stop_ack: got %b want 1", stop_ack); end
    n_chk++; if (golden_valid !== 1'b0) begin n_fail++; $display("FAIL reset_golden_valid: got %b want 0", golden_valid); end
    n_chk++; if (golden_nonce !== '0) begin n_fail++; $display("FAIL reset_golden_nonce: got %h want 0", golden_nonce); end
    n_chk++; if (golden_lane !== 2'd0) begin n_fail++; $display("FAIL reset_golden_lane: got %0d want 0", golden_lane); end
    n_chk++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (hash_re !== 4'b0001) begin n_fail++; $display("FAIL drain_hash_re: got %b want 0001", hash_re); end
    n_chk++; if (stop_ack !== 1'b0) begin n_fail++; $display("FAIL drain_stop_ack: got %b want 0", stop_ack); end
    @(negedge clk);
    n_chk++; if (hash_re !== 4'b0000) begin n_fail++; $display("FAIL drained_hash_re: got %b want 0000", hash_re); end
    n_chk++; if (stop_ack !== 1'b1) begin n_fail++; $display("FAIL drained_stop_ack: got %b want 1", stop_ack); end
  endtask

  task automatic test_round_robin();
    int exp_order [4] = '{0, 1, 3, 0};
    int got;
    chk_single = 1'b1;
    pop_log.delete();
    push(0, ONES, 64'h10);
    push(0, ONES, 64'h11);
    push(1, ONES, 64'h12);
    push(3, ONES, 64'h13);
    wait_pops(4);
    @(negedge clk);
    n_chk++; if (pop_log.size() !== 4) begin n_fail++; $display("FAIL rr_pop_count: got %0d want 4", pop_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < pop_log.size()) ? pop_log[i] : -1;
      n_chk++; if (got !== exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got lane %0d want lane %0d", i, got, exp_order[i]); end
    end
    n_chk++; if (golden_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_golden: got %b want 0", golden_valid); end
  endtask

  task automatic test_equal();
    int lat;
    int got;
    pop_log.delete();
    push_measure(1, T_VAL, 64'h20, lat);
    n_chk++; if (lat !== LAT_LAST) begin n_fail++; $display("FAIL equal_latency: got %0d want %0d", lat, LAT_LAST); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (golden_valid !== 1'b0) begin n_fail++; $display("FAIL equal_no_golden: got %b want 0", golden_valid); end
    end
    got = (pop_log.size() > 0) ? pop_log[0] : -1;
    n_chk++; if (pop_log.size() !== 1) begin n_fail++; $display("FAIL equal_pop_count: got %0d want 1", pop_log.size()); end
    n_chk++; if (got !== 1) begin n_fail++; $display("FAIL equal_pop_lane: got %0d want 1", got); end
    n_chk++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL equal_hit_count: got %0d want 0", hit_count); end
  endtask

  task automatic test_hit_report();
    bit ok;
    int got;
    pop_log.delete();
    tick();
    push(2, HIT_H, NONCE_A);
    wait_valid(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hit_golden_valid: got %b want 1", ok); end
    n_chk++; if (golden_lane !== 2'd2) begin n_fail++; $display("FAIL hit_golden_lane: got %0d want 2", golden_lane); end
    n_chk++; if (golden_nonce !== NONCE_A) begin n_fail++; $display("FAIL hit_golden_nonce: got %h want %h", golden_nonce, NONCE_A); end
    n_chk++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    push(0, ONES, 64'h30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++; if (golden_valid !== 1'b1) begin n_fail++; $display("FAIL report_hold_valid[%0d]: got %b want 1", i, golden_valid); end
      n_chk++; if (golden_nonce !== NONCE_A) begin n_fail++; $display("FAIL report_hold_nonce[%0d]: got %h want %h", i, golden_nonce, NONCE_A); end
    end
    n_chk++; if (pop_log.size() !== 1) begin n_fail++; $display("FAIL report_no_pops: got %0d pops want 1", pop_log.size()); end
    tick();
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (golden_valid !== 1'b0) begin n_fail++; $display("FAIL report_release: got %b want 0", golden_valid); end
    wait_pops(2);
    got = (pop_log.size() > 1) ? pop_log[1] : -1;
    n_chk++; if (got !== 0) begin n_fail++; $display("FAIL resume_pop_lane: got %0d want 0", got); end
  endtask

  task automatic test_latency();
    int lat;
    bit ok;
    push_measure(1, ONES, 64'h40, lat);
    n_chk++; if (lat !== LAT_FIRST) begin n_fail++; $display("FAIL latency_first_chunk: got %0d want %0d", lat, LAT_FIRST); end
    push_measure(3, LAST_H, NONCE_B, lat);
    n_chk++; if (lat !== LAT_LAST) begin n_fail++; $display("FAIL latency_last_chunk: got %0d want %0d", lat, LAT_LAST); end
    wait_valid(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL last_hit_valid: got %b want 1", ok); end
    n_chk++; if (golden_lane !== 2'd3) begin n_fail++; $display("FAIL last_hit_lane: got %0d want 3", golden_lane); end
    n_chk++; if (golden_nonce !== NONCE_B) begin n_fail++; $display("FAIL last_hit_nonce: got %h want %h", golden_nonce, NONCE_B); end
    n_chk++; if (hit_count !== 32'd2) begin n_fail++; $display("FAIL last_hit_count: got %0d want 2", hit_count); end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    n_chk++; if (golden_valid !== 1'b0) begin n_fail++; $display("FAIL stop_report_valid: got %b want 0", golden_valid); end
    n_chk++; if (stop_ack !== 1'b1) begin n_fail++; $display("FAIL stop_report_ack: got %b want 1", stop_ack); end
  endtask

  task automatic test_stop_load();
    logic [HW-1:0] t;
    t = T_VAL;
    chk_single = 1'b0;
    pop_log.delete();
    @(negedge clk);
    n_chk++; if (stop_ack !== 1'b1) begin n_fail++; $display("FAIL stop_idle_ack: got %b want 1", stop_ack); end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    push(0, ONES, 64'h50);
    push(0, ONES, 64'h51);
    push(2, ONES, 64'h52);
    for (int i = 0; i <= 5; i++) begin
      target       = t[i*32 +: 32];
      target_valid = 1'b1;
      if (i == 5) stop = 1'b1;
      tick();
    end
    stop         = 1'b0;
    target_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (hash_re !== 4'b0101) begin n_fail++; $display("FAIL stop_drain_re: got %b want 0101", hash_re); end
    n_chk++; if (stop_ack !== 1'b0) begin n_fail++; $display("FAIL stop_drain_ack: got %b want 0", stop_ack); end
    for (int c = 0; c < 20 && !all_empty; c++) @(negedge clk);
    n_chk++; if (stop_ack !== 1'b1) begin n_fail++; $display("FAIL stop_drained_ack: got %b want 1", stop_ack); end
    n_chk++; if (hash_re !== 4'b0000) begin n_fail++; $display("FAIL stop_drained_re: got %b want 0000", hash_re); end
    n_chk++; if (pop_log.size() !== 3) begin n_fail++; $display("FAIL stop_drain_pops: got %0d want 3", pop_log.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < L; l++) cnt[l] = 0;
    drive_fifos();
    test_reset();
    load_target(T_VAL);
    test_round_robin();
    test_equal();
    test_hit_report();
    test_latency();
    test_stop_load();
    n_chk++; if (bad_pop !== 0) begin n_fail++; $display("FAIL pop_on_empty: got %0d want 0", bad_pop); end
    n_chk++; if (multi !== 0) begin n_fail++; $display("FAIL multi_bit_pop: got %0d want 0", multi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_lane_comparator.md
MULTI_LANE_COMPARATOR -- requirements
Module: multi_lane_comparator

Interface
REQ-001 SHALL have parameter HASH_W, default 256; hash and target width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 64; bits compared per cycle; HASH_W%CHUNK_W==0, HASH_W%32==0.
REQ-003 SHALL have parameter LANES, default 4; number of hash FIFO lanes.
REQ-004 SHALL have parameter NONCE_W, default 64; nonce tag width.
REQ-005 SHALL have ports: clk in 1, global clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports: start in 1, arm; stop in 1, abort; stop_ack out 1, idle/drained acknowledge.
REQ-007 SHALL have ports: target in 32, target word; target_valid in 1, word strobe.
REQ-008 SHALL have ports: all_empty in 1, all upstream FIFOs empty.
REQ-009 SHALL have per-lane ports: hash_in in LANES*HASH_W; nonce_in in LANES*NONCE_W; hash_empty in LANES; hash_re out LANES, one-hot pop (FWFT FIFOs).
REQ-010 SHALL have ports: golden_valid out 1; golden_ready in 1; golden_nonce out NONCE_W; golden_lane out clog2(LANES); hit_count out 32.

Function
REQ-011 SHALL implement FSM states DRAIN, LOAD, ARB, COMPARE, REPORT.
REQ-012 DRAIN: hash_re asserted for every non-empty lane, stop_ack=0; when all_empty=1: hash_re=0, stop_ack=1; start=1 then -> LOAD, load counter cleared.
REQ-013 LOAD: each cycle with target_valid=1 shifts target in LSW-first ({target,reg[HASH_W-1:32]}); after HASH_W/32 words -> ARB; stop_ack=0.
REQ-014 ARB: round-robin grant among lanes with hash_empty=0, starting after last granted lane; grant latched; no grant -> stay ARB.
REQ-015 COMPARE: chunk k (MSB first) compared per cycle; hash chunk < target chunk -> hit; > -> miss; == -> next chunk; all chunks equal -> miss (strict less-than).
REQ-016 On miss: one-cycle hash_re pulse on granted lane, -> ARB.
REQ-017 On hit: latch nonce_in and lane, one-cycle hash_re pulse, hit_count+1 (saturating at 2^32-1), -> REPORT.
REQ-018 REPORT: golden_valid=1, golden_nonce/golden_lane stable until golden_ready=1 sampled; then golden_valid=0, -> ARB (search continues).
REQ-019 stop=1 in any state except DRAIN -> DRAIN next cycle, overriding all other transitions; pending golden result discarded; target retained.
REQ-020 hash_re SHALL never assert on an empty lane and at most one bit outside DRAIN.
REQ-021 Latency from grant to verdict: 1 to HASH_W/CHUNK_W cycles (early exit).

Reset
REQ-022 On rst: state=DRAIN, hash_re=0, stop_ack=1, golden_valid=0, golden_nonce=0, golden_lane=0, hit_count=0, target register=0, RR pointer=0, load counter=0.
REQ-023 rst mid-COMPARE/REPORT SHALL discard the result with no hash_re pulse.

Configuration
REQ-024 Macro MLC_CONST_LATENCY_EN defined: COMPARE always takes exactly HASH_W/CHUNK_W cycles, verdict from first differing chunk; undefined: early exit per REQ-015.

Structure
REQ-025 Package mlc_pkg SHALL hold the state enum and the NCHUNK/word-count constant functions.
REQ-026 Round-robin arbiter SHALL be sub-module mlc_rr_arbiter (req LANES, grant one-hot, advance strobe).

Verification
REQ-027 Target 0x0000_FFFF..FF (top 16 bits 0), lane 2 hash top 32 bits 0x0000_0001 -> hit, golden_lane=2, nonce echoed, hit_count=1.
REQ-028 Hash == target exactly -> miss, one hash_re pulse, no golden_valid.
REQ-029 Lanes 0,1,3 non-empty, all misses -> pop order 0,1,3,0 (round-robin).
REQ-030 golden_ready held 0 for 10 cycles -> golden_valid and nonce stable for 10 cycles, no pops during REPORT.
REQ-031 stop during LOAD word 5 -> DRAIN next cycle; FIFOs drained; stop_ack=1 once all_empty=1.
REQ-032 Difference in last chunk only, with and without MLC_CONST_LATENCY_EN -> 4 cycles both; difference in chunk 0 -> 1 vs 4 cycles.
